mem_access_ctrl: RTL and testbench

//  Load/store and stack sequencer between the multi-cycle datapath and the word-addressed data memory.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_access_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory access sequencer and the control unit:
// request op codes, sequencer state encodings and a small op classifier.
package mem_pkg;

  typedef enum logic [1:0] {
    OP_LW   = 2'd0,
    OP_SW   = 2'd1,
    OP_PUSH = 2'd2,
    OP_POP  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // LW and POP read memory; SW and PUSH write it.
  function automatic logic op_is_read(op_e op);
    return (op == OP_LW) || (op == OP_POP);
  endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Load/store and stack sequencer between the multi-cycle datapath and a
// word-addressed data memory. One request at a time; drives registered memory
// strobes, captures read data after READ_LAT cycles and owns the stack pointer.
//
// Handshake: req_valid is sampled only while the sequencer is idle (busy=0 and
// no done pulse pending). An accepted request ends with exactly one done pulse,
// a rejected one with exactly one err pulse in the cycle after it was
// presented. req_valid seen while busy or during done is dropped, not queued.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int SP_INIT  = 256,
  parameter int SP_LIMIT = 192,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_signal,
  output logic              mem_read_signal,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam int CNT_W = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);
  localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] SP_INIT_A  = ADDR_W'(SP_INIT);
  localparam logic [ADDR_W-1:0] SP_LIMIT_A = ADDR_W'(SP_LIMIT);
  // WAIT lasts READ_LAT cycles; the counter reaches 0 in the last of them.
  localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(READ_LAT - 1);

  state_e            state;
  state_e            state_nx;
  op_e               op_q;
  op_e               req_op_e;
  logic [ADDR_W-1:0] sp_q;
  logic [ADDR_W-1:0] ea;
  logic              legal;
  logic [CNT_W-1:0]  cnt_q;

  assign req_op_e = op_e'(req_op);

  // Effective address and legality of the request currently on the inputs.
  always_comb begin
    ea    = req_addr;
    legal = 1'b1;
    case (req_op_e)
      OP_LW, OP_SW: legal = (req_addr < DEPTH_A);
      OP_PUSH: begin
        ea    = sp_q - 1'b1;
        legal = (sp_q != SP_LIMIT_A);
      end
      OP_POP: begin
        ea    = sp_q;
        legal = (sp_q != SP_INIT_A);
      end
      default: ;
    endcase
  end

  // Next-state logic: rejected requests never leave IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (req_valid && legal) state_nx = ST_ISSUE;
      ST_ISSUE: state_nx = op_is_read(op_q) ? ST_WAIT : ST_DONE;
      ST_WAIT:  if (cnt_q == '0) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Datapath: strobes are set on the edge entering ISSUE so they are high
  // exactly during ISSUE (and WAIT for reads); sp moves on the DONE edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q             <= OP_LW;
      sp_q             <= SP_INIT_A;
      cnt_q            <= '0;
      err              <= 1'b0;
      rdata            <= '0;
      mem_addr         <= '0;
      mem_data_in      <= '0;
      mem_write_signal <= 1'b0;
      mem_read_signal  <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (legal) begin
              op_q     <= req_op_e;
              mem_addr <= ea;
              if (op_is_read(req_op_e)) begin
                mem_read_signal <= 1'b1;
              end else begin
                mem_write_signal <= 1'b1;
                mem_data_in      <= req_wdata;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          mem_write_signal <= 1'b0;
          cnt_q            <= CNT_LOAD;
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            rdata           <= mem_data_out;
            mem_read_signal <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          if (op_q == OP_PUSH) sp_q <= sp_q - 1'b1;
          if (op_q == OP_POP)  sp_q <= sp_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ST_ISSUE) || (state == ST_WAIT);
  assign done = (state == ST_DONE);
  assign sp   = sp_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: a simple synchronous memory behind the
// strobes, a strobe monitor, and a reference model of the request rules
// (word array plus stack pointer) that predicts outcome, latency and data.
module tb_mem_access_ctrl;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 256;
  localparam int SP_INIT  = 256;
  localparam int SP_LIMIT = 192;
  localparam int READ_LAT = 1;

  localparam logic [1:0] LW = 2'd0, SW = 2'd1, PUSH = 2'd2, POP = 2'd3;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              busy, done, err;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] sp;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_write_signal, mem_read_signal;
  logic [DATA_W-1:0] mem_data_out;

  int total = 0;
  int bad   = 0;

  mem_access_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .SP_INIT(SP_INIT), .SP_LIMIT(SP_LIMIT), .READ_LAT(READ_LAT)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .done(done),
    .err(err), .rdata(rdata), .sp(sp), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_write_signal(mem_write_signal),
    .mem_read_signal(mem_read_signal), .mem_data_out(mem_data_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- memory behind the strobes (READ_LAT = 1) ----------------
  logic [DATA_W-1:0] bmem [0:DEPTH-1];
  initial for (int i = 0; i < DEPTH; i++) bmem[i] = '0;

  always @(posedge clk) begin
    if (mem_write_signal && mem_addr < DEPTH) bmem[mem_addr[7:0]] <= mem_data_in;
    if (mem_read_signal)
      mem_data_out <= (mem_addr < DEPTH) ? bmem[mem_addr[7:0]] : 'x;
  end

  // ---------------- strobe monitor ----------------
  int                wr_cnt = 0;
  int                rd_cnt = 0;
  int                done_cnt = 0;
  logic [ADDR_W-1:0] last_wr_addr = '0;
  logic [DATA_W-1:0] last_wr_data = '0;

  always @(negedge clk) begin
    if (mem_write_signal) begin
      wr_cnt++;
      last_wr_addr = mem_addr;
      last_wr_data = mem_data_in;
    end
    if (mem_read_signal) rd_cnt++;
    if (done) done_cnt++;
    total++;
    if ((mem_write_signal && mem_read_signal) !== 1'b0) begin
      bad++;
      $display("FAIL strobe_exclusive: wr=%b rd=%b at %0t", mem_write_signal, mem_read_signal, $time);
    end
  end

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  int                sp_m;
  logic [DATA_W-1:0] rdata_m;
  logic [DATA_W-1:0] exp_q[$];

  task automatic model_reset();
    sp_m    = SP_INIT;
    rdata_m = '0;
  endtask

  // Predicts rejection, acceptance-to-pulse latency and the held load result.
  task automatic model_op(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, output bit e,
                          output int lat, output logic [DATA_W-1:0] rd);
    e   = 1'b0;
    lat = 2;
    case (op)
      LW:   if (addr >= DEPTH) e = 1'b1;
            else begin rdata_m = ref_mem[addr[7:0]]; lat = 2 + READ_LAT; end
      SW:   if (addr >= DEPTH) e = 1'b1;
            else ref_mem[addr[7:0]] = wdata;
      PUSH: if (sp_m == SP_LIMIT) e = 1'b1;
            else begin sp_m = sp_m - 1; ref_mem[sp_m] = wdata; end
      default:
            if (sp_m == SP_INIT) e = 1'b1;
            else begin rdata_m = ref_mem[sp_m]; sp_m = sp_m + 1; lat = 2 + READ_LAT; end
    endcase
    if (e) lat = 1;
    rd = rdata_m;
  endtask

  // ---------------- driver ----------------
  // Presents one request for one cycle, then counts cycles until done/err.
  task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata,
                       output bit got_done, output bit got_err, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!done && !err && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got_done = done;
    got_err  = err;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b exp 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b exp 0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b exp 0", err); end
    total++; if (rdata !== '0) begin bad++; $display("FAIL reset_rdata: got %h exp 0", rdata); end
    total++; if (sp !== SP_INIT) begin bad++; $display("FAIL reset_sp: got %0d exp %0d", sp, SP_INIT); end
    total++; if (mem_addr !== '0 || mem_data_in !== '0) begin
      bad++; $display("FAIL reset_mem_bus: got addr=%h data=%h exp 0/0", mem_addr, mem_data_in); end
    total++; if (mem_write_signal !== 1'b0 || mem_read_signal !== 1'b0) begin
      bad++; $display("FAIL reset_strobes: got wr=%b rd=%b exp 0/0", mem_write_signal, mem_read_signal); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sw_lw();
    bit d, e, ee; int lat, elat; logic [DATA_W-1:0] erd; int w0, r0;
    w0 = wr_cnt;
    model_op(SW, 5, 32'hDEADBEEF, ee, elat, erd);
    issue(SW, 5, 32'hDEADBEEF, d, e, lat);
    total++; if (d !== 1'b1 || lat != elat) begin bad++; $display("FAIL sw_latency: got done=%b lat=%0d exp 1/%0d", d, lat, elat); end
    total++; if (wr_cnt - w0 != 1 || last_wr_addr !== 5 || last_wr_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL sw_strobe: got n=%0d addr=%h data=%h exp 1/5/deadbeef", wr_cnt - w0, last_wr_addr, last_wr_data); end
    r0 = rd_cnt;
    model_op(LW, 5, '0, ee, elat, erd);
    issue(LW, 5, '0, d, e, lat);
    total++; if (d !== 1'b1 || lat != elat) begin bad++; $display("FAIL lw_latency: got done=%b lat=%0d exp 1/%0d", d, lat, elat); end
    total++; if (rdata !== erd) begin bad++; $display("FAIL lw_rdata: got %h exp %h", rdata, erd); end
    total++; if (rd_cnt - r0 != READ_LAT + 1) begin bad++; $display("FAIL lw_read_cycles: got %0d exp %0d", rd_cnt - r0, READ_LAT + 1); end
  endtask

  task automatic test_stack();
    logic [1:0]        ops [4] = '{PUSH, PUSH, POP, POP};
    logic [DATA_W-1:0] dat [4] = '{32'h11111111, 32'h22222222, 32'h0, 32'h0};
    int                wa  [2] = '{255, 254};
    bit d, e, ee; int lat, elat; logic [DATA_W-1:0] erd;
    for (int i = 0; i < 4; i++) begin
      model_op(ops[i], '0, dat[i], ee, elat, erd);
      issue(ops[i], '0, dat[i], d, e, lat);
      total++; if (d !== 1'b1 || lat != elat) begin bad++; $display("FAIL stack_done[%0d]: got done=%b lat=%0d exp 1/%0d", i, d, lat, elat); end
      total++; if (sp !== sp_m) begin bad++; $display("FAIL stack_sp[%0d]: got %0d exp %0d", i, sp, sp_m); end
      if (i < 2) begin
        total++; if (last_wr_addr !== wa[i]) begin bad++; $display("FAIL stack_wr_addr[%0d]: got %0d exp %0d", i, last_wr_addr, wa[i]); end
      end else begin
        total++; if (rdata !== erd) begin bad++; $display("FAIL stack_rdata[%0d]: got %h exp %h", i, rdata, erd); end
      end
    end
  endtask

  task automatic test_errors();
    logic [1:0]        ops  [2] = '{POP, LW};
    logic [ADDR_W-1:0] adrs [2] = '{0, 256};
    bit d, e, ee; int lat, elat; logic [DATA_W-1:0] erd; int w0, r0; logic [DATA_W-1:0] rd0;
    for (int i = 0; i < 2; i++) begin
      w0 = wr_cnt; r0 = rd_cnt; rd0 = rdata;
      model_op(ops[i], adrs[i], '0, ee, elat, erd);
      issue(ops[i], adrs[i], '0, d, e, lat);
      total++; if (e !== ee || d !== 1'b0 || lat != elat) begin
        bad++; $display("FAIL err_pulse[%0d]: got err=%b done=%b lat=%0d exp %b/0/%0d", i, e, d, lat, ee, elat); end
      total++; if (wr_cnt != w0 || rd_cnt != r0) begin bad++; $display("FAIL err_no_strobe[%0d]: got wr=%0d rd=%0d exp 0/0", i, wr_cnt - w0, rd_cnt - r0); end
      total++; if (sp !== sp_m || rdata !== rd0) begin bad++; $display("FAIL err_state[%0d]: got sp=%0d rdata=%h exp %0d/%h", i, sp, rdata, sp_m, rd0); end
    end
  endtask

  task automatic test_overflow();
    bit d, e, ee; int lat, elat; logic [DATA_W-1:0] erd, wd;
    for (int i = 0; i < 65; i++) begin
      wd = $urandom;
      model_op(PUSH, '0, wd, ee, elat, erd);
      issue(PUSH, '0, wd, d, e, lat);
      total++; if (e !== ee || d !== !ee) begin bad++; $display("FAIL push_outcome[%0d]: got done=%b err=%b exp err=%b", i, d, e, ee); end
      if (i >= 63) begin
        total++; if (sp !== sp_m) begin bad++; $display("FAIL push_sp[%0d]: got %0d exp %0d", i, sp, sp_m); end
      end
    end
    for (int i = 0; i < 64; i++) begin
      model_op(POP, '0, '0, ee, elat, erd);
      exp_q.push_back(erd);
      issue(POP, '0, '0, d, e, lat);
      total++; if (d !== 1'b1 || rdata !== exp_q.pop_front()) begin bad++; $display("FAIL pop_rdata[%0d]: got done=%b rdata=%h exp 1/%h", i, d, rdata, erd); end
    end
    total++; if (sp !== SP_INIT) begin bad++; $display("FAIL pop_all_sp: got %0d exp %0d", sp, SP_INIT); end
  endtask

  task automatic test_random();
    bit d, e, ee; int lat, elat; logic [DATA_W-1:0] erd, wd; logic [1:0] op; logic [ADDR_W-1:0] a;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom_range(DEPTH, DEPTH + 40)) : ADDR_W'($urandom_range(0, 15));
      wd = $urandom;
      model_op(op, a, wd, ee, elat, erd);
      issue(op, a, wd, d, e, lat);
      total++; if (e !== ee || d !== !ee || lat != elat) begin
        bad++; $display("FAIL rand_outcome[%0d] op=%0d: got done=%b err=%b lat=%0d exp err=%b lat=%0d", i, op, d, e, lat, ee, elat); end
      total++; if (rdata !== erd || sp !== sp_m) begin
        bad++; $display("FAIL rand_state[%0d] op=%0d: got rdata=%h sp=%0d exp %h/%0d", i, op, rdata, sp, erd, sp_m); end
    end
  endtask

  task automatic test_reset_mid();
    bit d, e, ee; int lat, elat; logic [DATA_W-1:0] erd; int d0;
    model_op(PUSH, '0, 32'hA5A5A5A5, ee, elat, erd);
    issue(PUSH, '0, 32'hA5A5A5A5, d, e, lat);
    @(negedge clk);
    req_valid = 1'b1; req_op = LW; req_addr = 5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    total++; if (mem_read_signal !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL mid_in_wait: got rd=%b busy=%b exp 1/1", mem_read_signal, busy); end
    d0 = done_cnt;
    #1 reset = 1'b1;
    #1;
    total++; if (mem_read_signal !== 1'b0 || mem_write_signal !== 1'b0) begin
      bad++; $display("FAIL mid_strobes_drop: got rd=%b wr=%b exp 0/0", mem_read_signal, mem_write_signal); end
    total++; if (busy !== 1'b0 || done !== 1'b0 || sp !== SP_INIT) begin
      bad++; $display("FAIL mid_idle: got busy=%b done=%b sp=%0d exp 0/0/%0d", busy, done, sp, SP_INIT); end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (done_cnt != d0) begin bad++; $display("FAIL mid_no_done: got %0d done pulses exp 0", done_cnt - d0); end
    model_op(SW, 9, 32'h0BADF00D, ee, elat, erd);
    issue(SW, 9, 32'h0BADF00D, d, e, lat);
    total++; if (d !== 1'b1 || lat != elat || last_wr_addr !== 9) begin
      bad++; $display("FAIL mid_next_sw: got done=%b lat=%0d addr=%0d exp 1/%0d/9", d, lat, last_wr_addr, elat); end
  endtask

  task automatic test_back_to_back();
    int done_k[$]; int r0; bit ee; int elat; logic [DATA_W-1:0] erd;
    model_op(LW, 9, '0, ee, elat, erd);
    model_op(LW, 9, '0, ee, elat, erd);
    r0 = rd_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_op = LW; req_addr = 9;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done) done_k.push_back(k);
      if (k == 2 * (2 + READ_LAT) + 1) req_valid = 1'b0;
    end
    total++; if (done_k.size() != 2) begin bad++; $display("FAIL b2b_count: got %0d done pulses exp 2", done_k.size()); end
    else begin
      total++; if (done_k[0] != 2 + READ_LAT || done_k[1] != 2 * (2 + READ_LAT) + 1) begin
        bad++; $display("FAIL b2b_timing: got %0d,%0d exp %0d,%0d", done_k[0], done_k[1], 2 + READ_LAT, 2 * (2 + READ_LAT) + 1); end
    end
    total++; if (rd_cnt - r0 != 2 * (READ_LAT + 1)) begin bad++; $display("FAIL b2b_read_cycles: got %0d exp %0d", rd_cnt - r0, 2 * (READ_LAT + 1)); end
    total++; if (rdata !== erd) begin bad++; $display("FAIL b2b_rdata: got %h exp %h", rdata, erd); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    test_reset();
    test_sw_lw();
    test_stack();
    test_errors();
    test_overflow();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
